// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a program image from a byte stream into instruction
//               memory while holding the processor in reset, then releases
//               the processor once the image checksum has been verified.
//
//               Frame: N[7:0], N[15:8], N x 4 bytes (little-endian words),
//               then one checksum byte = XOR of every preceding frame byte.
//
// Ports       : clock      - system clock
//               reset      - asynchronous, active-low reset
//               rx_valid   - one-cycle strobe qualifying rx_data
//               rx_data    - received byte
//               start      - one-cycle pulse requesting a (re)load
//               imem_we    - instruction memory write enable (one clock/word)
//               imem_addr  - instruction memory word address
//               imem_wdata - instruction word to write
//               cpu_reset  - active-high processor reset
//               busy       - a load is in progress (LEN0..HOLD)
//               done       - image loaded and processor running
//               error      - load aborted (bad length, checksum or timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Counters only need to reach LIMIT-1.
  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4,
    S_HOLD  = 3'd5,
    S_RUN   = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [7:0]        count_lo;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_buf;
  logic [7:0]        csum;
  logic [IDLE_W-1:0] idle_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic              loading;
  logic              timed_out;
  logic [16:0]       n_full;

  // States in which the receiver is being listened to and the idle watchdog runs.
  assign loading   = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CHECK);
  // Fires on the TIMEOUT-th consecutive clock without a byte.
  assign timed_out = loading && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  // Full word count as it becomes known on the second count byte.
  assign n_full    = {1'b0, rx_data, count_lo};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    cpu_reset  = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) next_state = S_LEN0;
      end
      S_LEN0: begin
        busy = 1'b1;
        if (rx_valid) next_state = S_LEN1;
      end
      S_LEN1: begin
        busy = 1'b1;
        if (rx_valid) begin
          if (n_full > 17'(DEPTH))   next_state = S_ERR;
          else if (n_full == 17'd0)  next_state = S_CHECK;
          else                       next_state = S_DATA;
        end
      end
      S_DATA: begin
        busy = 1'b1;
        // The final word's write lands during the first CHECK cycle.
        if (rx_valid && (byte_cnt == 2'd3) && (word_idx == last_idx)) begin
          next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
        if (rx_valid) next_state = (rx_data == csum) ? S_HOLD : S_ERR;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) next_state = S_RUN;
      end
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (start) next_state = S_LEN0;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) next_state = S_LEN0;
      end
      default: next_state = S_IDLE;
    endcase

    if (timed_out) next_state = S_ERR;
  end

  // --------------------------------------------------------------------------
  // Datapath: word assembly, checksum, counters and memory write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_lo   <= '0;
      last_idx   <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      idle_cnt   <= '0;
      hold_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;

      if (loading) begin
        idle_cnt <= rx_valid ? '0 : idle_cnt + IDLE_W'(1);
      end

      case (state)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            csum     <= '0;
            idle_cnt <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
          end
        end
        S_LEN0: begin
          if (rx_valid) begin
            count_lo <= rx_data;
            csum     <= csum ^ rx_data;
          end
        end
        S_LEN1: begin
          if (rx_valid) begin
            last_idx <= ADDR_W'({rx_data, count_lo} - 16'd1);
            csum     <= csum ^ rx_data;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                // Fourth byte goes straight to the write port.
                imem_we    <= 1'b1;
                imem_addr  <= word_idx;
                imem_wdata <= {rx_data, word_buf};
                word_idx   <= word_idx + ADDR_W'(1);
              end
            endcase
          end
        end
        S_CHECK: begin
          hold_cnt <= '0;
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Self-checking bench for imem_boot_loader. A frame-level model
//               tracks byte positions within the frame to predict every
//               cycle's outputs; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int ADDR_W      = 12;
  localparam int DEPTH       = 4096;
  localparam int TIMEOUT     = 20;
  localparam int HOLD_CYCLES = 16;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_HOLD = 2;
  localparam int M_RUN  = 3;
  localparam int M_ERR  = 4;

  logic              clock;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  int vectors     = 0;
  int miscompares = 0;

  // Frame-level model state
  int                m_mode  = M_IDLE;
  logic [7:0]        m_bytes[$];
  int                m_n     = 0;
  int                m_idle  = 0;
  int                m_hold  = 0;
  logic              m_we    = 1'b0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [31:0]       m_wdata = '0;

  // Writes seen on the DUT port
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  // 02 00 | 13 00 50 00 | 93 00 A0 00 ; checksum of these is 0x72
  logic [7:0] frame_a [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50,
                               8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};

  imem_boot_loader #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .TIMEOUT     (TIMEOUT),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset();
    m_mode = M_IDLE;
    m_bytes.delete();
    m_idle = 0;
    m_hold = 0;
    m_we   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    int         b;
    logic [7:0] x;
    m_bytes.push_back(d);
    b = m_bytes.size();
    if (b == 2) begin
      m_n = int'({m_bytes[1], m_bytes[0]});
      if (m_n > DEPTH) m_mode = M_ERR;
    end else if (b > 2 && b <= 2 + 4 * m_n) begin
      if ((b - 2) % 4 == 0) begin
        m_we    = 1'b1;
        m_addr  = ADDR_W'((b - 2) / 4 - 1);
        m_wdata = {m_bytes[b-1], m_bytes[b-2], m_bytes[b-3], m_bytes[b-4]};
      end
    end else if (b == 3 + 4 * m_n) begin
      x = 8'h00;
      for (int i = 0; i < b - 1; i++) x = x ^ m_bytes[i];
      if (x == d) begin
        m_mode = M_HOLD;
        m_hold = HOLD_CYCLES;
      end else begin
        m_mode = M_ERR;
      end
    end
  endtask

  // Advance the model by one clock given the inputs sampled at that clock.
  task automatic model_step(input logic st, input logic v, input logic [7:0] d);
    m_we = 1'b0;
    case (m_mode)
      M_IDLE, M_RUN, M_ERR: begin
        if (st) begin
          m_mode = M_LOAD;
          m_bytes.delete();
          m_idle = 0;
        end
      end
      M_LOAD: begin
        if (v) begin
          m_idle = 0;
          model_byte(d);
        end else begin
          m_idle++;
          if (m_idle >= TIMEOUT) m_mode = M_ERR;
        end
      end
      M_HOLD: begin
        m_hold--;
        if (m_hold == 0) m_mode = M_RUN;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Compare on the falling edge, then step the model with the inputs that
  // the next rising edge will sample (inputs only change just after rising edges).
  initial begin : compare
    forever begin
      @(negedge clock);
      if (!reset) model_reset();
      chk("cpu_reset", 32'(cpu_reset), 32'(m_mode != M_RUN));
      chk("busy",      32'(busy),      32'(m_mode == M_LOAD || m_mode == M_HOLD));
      chk("done",      32'(done),      32'(m_mode == M_RUN));
      chk("error",     32'(error),     32'(m_mode == M_ERR));
      chk("imem_we",   32'(imem_we),   32'(m_we));
      if (m_we) begin
        chk("imem_addr",  32'(imem_addr), 32'(m_addr));
        chk("imem_wdata", imem_wdata,     m_wdata);
      end
      if (imem_we === 1'b1) begin
        wr_addr_q.push_back(imem_addr);
        wr_data_q.push_back(imem_wdata);
      end
      if (reset) model_step(start, rx_valid, rx_data);
    end
  end

  // ---------------- stimulus helpers (enter/leave 1 time unit after posedge) ----
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic send_frame_a(input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(frame_a[i]);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_addr",      32'(imem_addr), 32'd0);
    chk("rst_wdata",     imem_wdata,     32'd0);
    reset = 1'b1;
    idle(2);

    // Good two-word frame
    clear_writes();
    pulse_start();
    send_frame_a(0, 9);
    send_byte(8'h72);
    chk("t1_nwrites", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      chk("t1_addr0", 32'(wr_addr_q[0]), 32'd0);
      chk("t1_data0", wr_data_q[0],      32'h00500013);
      chk("t1_addr1", 32'(wr_addr_q[1]), 32'd1);
      chk("t1_data1", wr_data_q[1],      32'h00A00093);
    end
    idle(15);
    chk("t1_hold_done",  32'(done),      32'd0);
    chk("t1_hold_cpurst", 32'(cpu_reset), 32'd1);
    idle(1);
    chk("t1_run_done",   32'(done),      32'd1);
    chk("t1_run_cpurst", 32'(cpu_reset), 32'd0);

    // Bad checksum, then recovery
    pulse_start();
    chk("t2_cpurst_after_start", 32'(cpu_reset), 32'd1);
    send_frame_a(0, 9);
    send_byte(8'h73);
    chk("t2_error",  32'(error),     32'd1);
    chk("t2_cpurst", 32'(cpu_reset), 32'd1);
    idle(3);
    pulse_start();
    chk("t2_error_clear", 32'(error), 32'd0);
    send_frame_a(0, 9);
    send_byte(8'h72);
    idle(16);
    chk("t2_done", 32'(done), 32'd1);

    // Oversize count
    clear_writes();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h10);
    chk("t3_error", 32'(error), 32'd1);
    send_frame_a(2, 9);
    chk("t3_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Empty image
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("t4_busy", 32'(busy), 32'd1);
    idle(16);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Timeout after two data bytes
    pulse_start();
    send_frame_a(0, 3);
    idle(TIMEOUT - 1);
    chk("t5_no_err_yet", 32'(error), 32'd0);
    idle(1);
    chk("t5_timeout_err", 32'(error), 32'd1);
    send_frame_a(4, 9);
    send_byte(8'h72);
    chk("t5_still_err", 32'(error), 32'd1);
    chk("t5_nwrites", 32'(wr_addr_q.size()), 32'd0);

    // Stall just under the limit completes
    pulse_start();
    send_frame_a(0, 3);
    idle(TIMEOUT - 1);
    send_frame_a(4, 9);
    send_byte(8'h72);
    idle(16);
    chk("t5_stall_done", 32'(done), 32'd1);
    chk("t5_stall_nwrites", 32'(wr_addr_q.size()), 32'd2);

    // Asynchronous reset mid-DATA
    clear_writes();
    pulse_start();
    send_frame_a(0, 6);
    reset = 1'b0;
    #1;
    chk("t6_cpurst", 32'(cpu_reset), 32'd1);
    chk("t6_busy",   32'(busy),      32'd0);
    chk("t6_we",     32'(imem_we),   32'd0);
    chk("t6_addr",   32'(imem_addr), 32'd0);
    chk("t6_wdata",  imem_wdata,     32'd0);
    idle(2);
    reset = 1'b1;
    idle(1);
    pulse_start();
    send_frame_a(0, 9);
    send_byte(8'h72);
    idle(16);
    chk("t6_done", 32'(done), 32'd1);

    // Reload from RUN
    clear_writes();
    pulse_start();
    chk("t7_cpurst", 32'(cpu_reset), 32'd1);
    chk("t7_done",   32'(done),      32'd0);
    send_frame_a(0, 9);
    send_byte(8'h72);
    idle(16);
    chk("t7_reload_done", 32'(done), 32'd1);
    chk("t7_nwrites", 32'(wr_addr_q.size()), 32'd2);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
